// File: rtl/ysyx_23060332_wbu.sv
// ysyx_23060332_wbu: write-back unit.
// Buffers EXU/LSU results in a 2-entry in-order FIFO and aligns load data
// at push time. It retires one entry per cycle unless wb_stall holds it,
// and drives the regfile write port and the commit pulse from registers.
// It also reports pending writes to the IDU so that RAW hazards can be detected.
//
// Handshake: a result transfers on any posedge where in_valid && in_ready.
// in_ready depends only on FIFO fullness and rst, never on in_valid.
// When the FIFO is full, a pop in the same cycle does not make room for a push.
module ysyx_23060332_wbu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic        in_is_load,
  input  logic [2:0]  in_ld_type,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_data,
  input  logic [31:0] in_pc,
  input  logic        wb_stall,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        reg_wen,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  input  logic [4:0]  chk_raddr1,
  input  logic [4:0]  chk_raddr2,
  output logic        hazard1,
  output logic        hazard2,
  output logic [31:0] retire_cnt
);

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t      r_fifo [2];
  logic        r_head;
  logic [1:0]  r_count;

  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic        r_reg_wen;
  logic        r_commit_valid;
  logic [31:0] r_commit_pc;
  logic [31:0] r_retire_cnt;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_tail;
  logic [31:0] w_aligned;
  logic [1:0]  w_ent_valid;
  entry_t      w_head_ent;

  // Aligns and extends a raw memory word according to the load funct3.
  // For a halfword load only addr_lo[1] selects the half.
  function automatic logic [31:0] load_align(input logic [2:0]  ld_type,
                                             input logic [1:0]  addr_lo,
                                             input logic [31:0] data);
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    logic [31:0] v_res;
    v_byte = data[8*addr_lo +: 8];
    v_half = addr_lo[1] ? data[31:16] : data[15:0];
    case (ld_type)
      3'b000:  v_res = {{24{v_byte[7]}}, v_byte};
      3'b100:  v_res = {24'd0, v_byte};
      3'b001:  v_res = {{16{v_half[15]}}, v_half};
      3'b101:  v_res = {16'd0, v_half};
      default: v_res = data;
    endcase
    return v_res;
  endfunction

  assign w_full     = (r_count == 2'd2);
  assign w_empty    = (r_count == 2'd0);
  assign in_ready   = !w_full && !rst;
  assign w_push     = in_valid && in_ready;
  assign w_pop      = !w_empty && !wb_stall;
  assign w_tail     = r_head ^ r_count[0];
  assign w_aligned  = in_is_load ? load_align(in_ld_type, in_addr_lo, in_data) : in_data;
  assign w_head_ent = r_fifo[r_head];

  // An entry is live if the FIFO is full, or if it is the only entry and sits at the head.
  always_comb begin
    w_ent_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_ent_valid[i] = w_full || ((r_count == 2'd1) && (r_head == i[0]));
    end
  end

  // Store the already-aligned result at the tail. Payload needs no reset because occupancy gates it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[w_tail] <= '{rd: in_rd, wen: in_wen, data: w_aligned, pc: in_pc};
    end
  end

  // Update the FIFO pointers, the registered commit outputs and the retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head         <= 1'b0;
      r_count        <= 2'd0;
      r_waddr        <= 5'd0;
      r_wdata        <= 32'd0;
      r_reg_wen      <= 1'b0;
      r_commit_valid <= 1'b0;
      r_commit_pc    <= 32'd0;
      r_retire_cnt   <= 32'd0;
    end else begin
      r_count        <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_commit_valid <= w_pop;
      r_reg_wen      <= w_pop && w_head_ent.wen && (w_head_ent.rd != 5'd0);
      if (w_pop) begin
        r_head       <= ~r_head;
        r_waddr      <= w_head_ent.rd;
        r_wdata      <= w_head_ent.data;
        r_commit_pc  <= w_head_ent.pc;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  // Raise a hazard for a nonzero source that has a buffered write or a write in progress this cycle.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (w_ent_valid[i] && r_fifo[i].wen && (r_fifo[i].rd == chk_raddr1)) hazard1 = 1'b1;
      if (w_ent_valid[i] && r_fifo[i].wen && (r_fifo[i].rd == chk_raddr2)) hazard2 = 1'b1;
    end
    if (r_reg_wen && (r_waddr == chk_raddr1)) hazard1 = 1'b1;
    if (r_reg_wen && (r_waddr == chk_raddr2)) hazard2 = 1'b1;
    if (chk_raddr1 == 5'd0) hazard1 = 1'b0;
    if (chk_raddr2 == 5'd0) hazard2 = 1'b0;
  end

  assign waddr        = r_waddr;
  assign wdata        = r_wdata;
  assign reg_wen      = r_reg_wen;
  assign commit_valid = r_commit_valid;
  assign commit_pc    = r_commit_pc;
  assign retire_cnt   = r_retire_cnt;

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Bench for ysyx_23060332_wbu: a table of single-result vectors, followed by
// hand-written stall, counter-wrap and mid-operation reset sequences.
module tb_ysyx_23060332_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_ld_type = '0;
  logic [1:0]  in_addr_lo = '0;
  logic [31:0] in_data = '0;
  logic [31:0] in_pc = '0;
  logic        wb_stall = 1'b0;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        reg_wen;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  chk_raddr1 = '0;
  logic [4:0]  chk_raddr2 = '0;
  logic        hazard1;
  logic        hazard2;
  logic [31:0] retire_cnt;

  ysyx_23060332_wbu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
    .in_ld_type(in_ld_type), .in_addr_lo(in_addr_lo), .in_data(in_data),
    .in_pc(in_pc), .wb_stall(wb_stall), .waddr(waddr), .wdata(wdata),
    .reg_wen(reg_wen), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2),
    .hazard1(hazard1), .hazard2(hazard2), .retire_cnt(retire_cnt)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic        is_load;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] exp_wdata;
    logic        exp_reg_wen;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver: present one result for a single push edge
  task automatic drive(input logic [4:0] rd, input logic wen, input logic is_load,
                       input logic [2:0] ld_type, input logic [1:0] addr_lo,
                       input logic [31:0] data, input logic [31:0] pc);
    in_valid   = 1'b1;
    in_rd      = rd;
    in_wen     = wen;
    in_is_load = is_load;
    in_ld_type = ld_type;
    in_addr_lo = addr_lo;
    in_data    = data;
    in_pc      = pc;
  endtask

  // Run one vector through an empty, unstalled FIFO and check the two-edge latency and the commit.
  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v.rd, v.wen, v.is_load, v.ld_type, v.addr_lo, v.data, v.pc);
    #1 check({s, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    chk_raddr1 = v.rd;
    #1;
    check({s, "_no_commit_yet"}, commit_valid, 0);
    check({s, "_hazard1_buffered"}, hazard1, v.wen && (v.rd != 5'd0));
    @(posedge clk);
    @(negedge clk);
    exp_cnt++;
    chk_raddr2 = v.rd;
    #1;
    check({s, "_commit_valid"}, commit_valid, 1);
    check({s, "_reg_wen"}, reg_wen, v.exp_reg_wen);
    check({s, "_waddr"}, waddr, v.rd);
    check({s, "_wdata"}, wdata, v.exp_wdata);
    check({s, "_commit_pc"}, commit_pc, v.pc);
    check({s, "_retire_cnt"}, retire_cnt, exp_cnt);
    check({s, "_hazard2_writing"}, hazard2, v.exp_reg_wen);
    @(negedge clk);
    check({s, "_commit_drop"}, commit_valid, 0);
    check({s, "_reg_wen_drop"}, reg_wen, 0);
    check({s, "_wdata_hold"}, wdata, v.exp_wdata);
  endtask

  initial begin
    vecs[0]  = '{5'd5,  1'b1, 1'b0, 3'b000, 2'd0, 32'h12345678, 32'h80000000, 32'h12345678, 1'b1};
    vecs[1]  = '{5'd6,  1'b1, 1'b1, 3'b000, 2'd3, 32'h80FF7F01, 32'h80000004, 32'hFFFFFF80, 1'b1};
    vecs[2]  = '{5'd7,  1'b1, 1'b1, 3'b100, 2'd2, 32'h80FF7F01, 32'h80000008, 32'h000000FF, 1'b1};
    vecs[3]  = '{5'd8,  1'b1, 1'b1, 3'b001, 2'd2, 32'h80FF7F01, 32'h8000000C, 32'hFFFF80FF, 1'b1};
    vecs[4]  = '{5'd9,  1'b1, 1'b1, 3'b101, 2'd1, 32'h80FF7F01, 32'h80000010, 32'h00007F01, 1'b1};
    vecs[5]  = '{5'd10, 1'b1, 1'b1, 3'b010, 2'd0, 32'h80FF7F01, 32'h80000014, 32'h80FF7F01, 1'b1};
    vecs[6]  = '{5'd11, 1'b1, 1'b1, 3'b011, 2'd3, 32'h80FF7F01, 32'h80000018, 32'h80FF7F01, 1'b1};
    vecs[7]  = '{5'd12, 1'b1, 1'b1, 3'b110, 2'd1, 32'h80FF7F01, 32'h8000001C, 32'h80FF7F01, 1'b1};
    vecs[8]  = '{5'd13, 1'b1, 1'b1, 3'b001, 2'd3, 32'h80FF7F01, 32'h80000020, 32'hFFFF80FF, 1'b1};
    vecs[9]  = '{5'd0,  1'b1, 1'b0, 3'b000, 2'd0, 32'h0000BEEF, 32'h80000024, 32'h0000BEEF, 1'b0};
    vecs[10] = '{5'd14, 1'b0, 1'b0, 3'b000, 2'd0, 32'h00000042, 32'h80000028, 32'h00000042, 1'b0};
    vecs[11] = '{5'd15, 1'b1, 1'b0, 3'b000, 2'd3, 32'hDEADBEEF, 32'h8000002C, 32'hDEADBEEF, 1'b1};
    vecs[12] = '{5'd16, 1'b1, 1'b1, 3'b100, 2'd0, 32'h80FF7F01, 32'h80000030, 32'h00000001, 1'b1};
    vecs[13] = '{5'd31, 1'b1, 1'b1, 3'b111, 2'd2, 32'hCAFEF00D, 32'h80000034, 32'hCAFEF00D, 1'b1};

    // Power-on reset
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_raddr1 = 5'd5;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_reg_wen", reg_wen, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    check("rst_waddr", waddr, 0);
    check("rst_hazard1", hazard1, 0);
    rst = 1'b0;
    #1 check("rel_in_ready", in_ready, 1);

    // Table-driven single results
    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Counter wrap: preload all ones, then retire one instruction
    @(negedge clk);
    force dut.r_retire_cnt = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.r_retire_cnt;
    drive(5'd3, 1'b1, 1'b0, 3'b000, 2'd0, 32'h00000077, 32'h80000100);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("wrap_commit_valid", commit_valid, 1);
    check("wrap_retire_cnt", retire_cnt, 0);
    exp_cnt = 32'd0;

    // Stall: two results fill the FIFO and the third is held until the stall releases
    wb_stall = 1'b1;
    drive(5'd20, 1'b1, 1'b0, 3'b000, 2'd0, 32'hA0A0A0A0, 32'h80000200);
    exp_q.push_back(32'hA0A0A0A0);
    @(posedge clk);
    @(negedge clk);
    check("stall_ready_after1", in_ready, 1);
    drive(5'd21, 1'b1, 1'b0, 3'b000, 2'd0, 32'hB1B1B1B1, 32'h80000204);
    exp_q.push_back(32'hB1B1B1B1);
    @(posedge clk);
    @(negedge clk);
    check("stall_ready_full", in_ready, 0);
    drive(5'd22, 1'b1, 1'b0, 3'b000, 2'd0, 32'hC2C2C2C2, 32'h80000208);
    @(posedge clk);
    @(negedge clk);
    chk_raddr1 = 5'd21;
    chk_raddr2 = 5'd22;
    #1;
    check("stall_held_ready", in_ready, 0);
    check("stall_no_commit", commit_valid, 0);
    check("stall_hazard1_buffered", hazard1, 1);
    check("stall_hazard2_held", hazard2, 0);
    check("stall_cnt_frozen", retire_cnt, 0);
    exp_q.push_back(32'hC2C2C2C2);
    wb_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] e;
      @(posedge clk);
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      exp_cnt++;
      e = exp_q.pop_front();
      check($sformatf("drain%0d_commit", k), commit_valid, 1);
      check($sformatf("drain%0d_wdata", k), wdata, e);
      check($sformatf("drain%0d_waddr", k), waddr, 5'd20 + 5'(k));
      check($sformatf("drain%0d_cnt", k), retire_cnt, exp_cnt);
    end
    @(negedge clk);
    check("drain_done", commit_valid, 0);

    // Asynchronous reset with two entries buffered
    wb_stall = 1'b1;
    drive(5'd23, 1'b1, 1'b0, 3'b000, 2'd0, 32'hD3D3D3D3, 32'h80000300);
    @(posedge clk);
    @(negedge clk);
    drive(5'd24, 1'b1, 1'b0, 3'b000, 2'd0, 32'hE4E4E4E4, 32'h80000304);
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    chk_raddr1 = 5'd23;
    chk_raddr2 = 5'd24;
    #1 check("pre_rst_hazard1", hazard1, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_waddr", waddr, 0);
    check("arst_wdata", wdata, 0);
    check("arst_commit_pc", commit_pc, 0);
    check("arst_retire_cnt", retire_cnt, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_hazard1", hazard1, 0);
    check("arst_hazard2", hazard2, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wb_stall = 1'b0;
    #1 check("arst_rel_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("arst_no_commit%0d", k), commit_valid, 0);
      check($sformatf("arst_cnt%0d", k), retire_cnt, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ysyx_23060332_wbu.md
YSYX_23060332_WBU -- requirements
Module: ysyx_23060332_wbu

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset, which clears all state immediately on assertion.
REQ-003 SHALL have port in_valid, input, 1: the EXU/LSU result is valid.
REQ-004 SHALL have port in_ready, output, 1: the unit can accept a result this cycle.
REQ-005 SHALL have port in_rd, input, 5: destination register index.
REQ-006 SHALL have port in_wen, input, 1: the result writes a register.
REQ-007 SHALL have port in_is_load, input, 1: in_data is a raw memory word.
REQ-008 SHALL have port in_ld_type, input, 3: load funct3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
REQ-009 SHALL have port in_addr_lo, input, 2: byte offset of the load address.
REQ-010 SHALL have port in_data, input, 32: ALU result or raw load word.
REQ-011 SHALL have port in_pc, input, 32: PC of the instruction.
REQ-012 SHALL have port wb_stall, input, 1: blocks retirement (debug/difftest hold).
REQ-013 SHALL have port waddr, output, 5: regfile write index.
REQ-014 SHALL have port wdata, output, 32: regfile write data.
REQ-015 SHALL have port reg_wen, output, 1: regfile write enable.
REQ-016 SHALL have port commit_valid, output, 1: one-cycle pulse per retired instruction.
REQ-017 SHALL have port commit_pc, output, 32: PC of the retired instruction.
REQ-018 SHALL have ports chk_raddr1 and chk_raddr2, input, 5 each: IDU source indices.
REQ-019 SHALL have ports hazard1 and hazard2, output, 1 each: a pending write to the matching source exists.
REQ-020 SHALL have port retire_cnt, output, 32: count of retired instructions.

Function
REQ-021 SHALL buffer accepted results in a 2-entry in-order FIFO; a push occurs when in_valid && in_ready.
REQ-022 SHALL drive in_ready = !full && !rst; when the FIFO is full, no push occurs even if a pop happens in the same cycle.
REQ-023 SHALL pop the head at each posedge while the FIFO is non-empty and wb_stall=0.
REQ-024 SHALL register the outputs: a pop loads waddr, wdata, commit_pc, and sets commit_valid=1 and reg_wen=(wen && rd!=0) for exactly the following cycle.
REQ-025 SHALL clear commit_valid and reg_wen to 0 in any cycle after an edge with no pop; waddr, wdata and commit_pc hold their values.
REQ-026 SHALL give 2 edges of latency on an empty FIFO: a push at edge E0 is followed by a pop at E1, so the outputs are valid during the cycle after E1.
REQ-027 SHALL produce wdata for non-loads equal to in_data unchanged.
REQ-028 SHALL, for lb/lbu, select byte in_addr_lo of in_data and sign-extend it (lb) or zero-extend it (lbu).
REQ-029 SHALL, for lh/lhu, select halfword in_addr_lo[1] of in_data, ignore in_addr_lo[0], and sign-extend (lh) or zero-extend (lhu).
REQ-030 SHALL pass in_data unchanged for lw and for the undefined ld_type values 011, 110 and 111.
REQ-031 SHALL retire an entry with rd=0 or wen=0 normally (commit_valid=1, retire_cnt increments) while keeping reg_wen=0.
REQ-032 SHALL increment retire_cnt by 1 on each pop, wrapping from 0xFFFFFFFF to 0.
REQ-033 SHALL assert hazardN combinationally when chk_raddrN!=0 and any valid FIFO entry has wen=1 and rd equal to chk_raddrN.
REQ-034 SHALL also assert hazardN when reg_wen=1 and waddr equals chk_raddrN.
REQ-035 SHALL, on a simultaneous push and pop with one entry occupied, leave the occupancy at 1 with FIFO order preserved.

Reset
REQ-036 SHALL, while rst is high, force FIFO occupancy to 0, reg_wen=0, commit_valid=0, waddr=0, wdata=0, commit_pc=0, retire_cnt=0, in_ready=0 and hazard1=hazard2=0.
REQ-037 SHALL discard any entries in flight when rst asserts mid-operation, with no commit afterwards; after release, in_ready=1 in the first cycle.

Verification
REQ-038 SHALL be tested by pushing rd=5, wen=1, non-load, data=0x12345678, pc=0x80000000 into an empty FIFO -> 2 edges later reg_wen=1, waddr=5, wdata=0x12345678, commit_pc=0x80000000 and retire_cnt=1 for one cycle.
REQ-039 SHALL be tested with loads of data=0x80FF7F01: lb at offset 3 -> 0xFFFFFF80; lbu at offset 2 -> 0x000000FF; lh at offset 2 -> 0xFFFF80FF; lhu at offset 1 -> 0x00007F01.
REQ-040 SHALL be tested by pushing rd=0, wen=1 -> commit_valid=1, reg_wen=0 and retire_cnt incremented.
REQ-041 SHALL be tested by holding wb_stall=1 and pushing 3 results -> in_ready=0 after 2 pushes, the third is held, and hazard1=1 for chk_raddr1 equal to a buffered rd; then releasing the stall -> 3 commits in order on consecutive cycles.
REQ-042 SHALL be tested by asserting rst asynchronously between clock edges with 2 entries buffered -> all outputs are 0 immediately and no commit follows release.
REQ-043 SHALL be tested by preloading retire_cnt to 0xFFFFFFFF via 2^32-1 retirements (or forcing the count) and then retiring one instruction -> retire_cnt=0.
